// File: rtl/hi_lo_muldiv_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module      : hi_lo_muldiv_unit_pkg
// Description : Op encodings, FSM state codes and small decode helpers used by
//               the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
//==============================================================================
package hi_lo_muldiv_unit_pkg;

   localparam int OP_WIDTH = 3;

   typedef logic [OP_WIDTH-1:0] op_t;

   localparam op_t OP_NOP   = 3'd0;
   localparam op_t OP_MULT  = 3'd1;
   localparam op_t OP_MULTU = 3'd2;
   localparam op_t OP_DIV   = 3'd3;
   localparam op_t OP_DIVU  = 3'd4;
   localparam op_t OP_MTHI  = 3'd5;
   localparam op_t OP_MTLO  = 3'd6;
   localparam op_t OP_MADD  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   // Signed ops take magnitudes up front and fix the sign after the last step.
   function automatic logic isSignedOp(input op_t op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
   endfunction

   function automatic logic isDivOp(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hi_lo_muldiv_unit_if.sv
`default_nettype none
//==============================================================================
// Module      : hi_lo_muldiv_unit_if
// Description : Execute-stage request / HI-LO read bundle for the mul/div unit.
// Revision    : 1.0 - initial release
//==============================================================================
interface hi_lo_muldiv_unit_if
   import hi_lo_muldiv_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic                  Start;
   logic [OP_WIDTH-1:0]   Op;
   logic [DATA_WIDTH-1:0] OperandA;
   logic [DATA_WIDTH-1:0] OperandB;
   logic [DATA_WIDTH-1:0] ReadDataHi;
   logic [DATA_WIDTH-1:0] ReadDataLo;
   logic                  Busy;

   modport master (
      output Start, Op, OperandA, OperandB,
      input  ReadDataHi, ReadDataLo, Busy
   );

   modport slave (
      input  Start, Op, OperandA, OperandB,
      output ReadDataHi, ReadDataLo, Busy
   );
endinterface
`default_nettype wire

// File: rtl/hi_lo_muldiv_unit_step.sv
`default_nettype none
//==============================================================================
// Module      : iter_muldiv_step
// Description : One combinational iteration of an unsigned shift-add multiply
//               or a restoring divide on the {acc, low} register pair.
// Revision    : 1.0 - initial release
//==============================================================================
module iter_muldiv_step #(
   parameter int DATA_WIDTH = 32
) (
   input  wire logic                  i_isDiv,
   input  wire logic [DATA_WIDTH-1:0] i_acc,
   input  wire logic [DATA_WIDTH-1:0] i_low,
   input  wire logic [DATA_WIDTH-1:0] i_operand,
   output logic      [DATA_WIDTH-1:0] o_acc,
   output logic      [DATA_WIDTH-1:0] o_low
);
   logic [DATA_WIDTH:0] w_mulSum;
   logic [DATA_WIDTH:0] w_divShift;
   logic [DATA_WIDTH:0] w_divDiff;

   // Mul: add multiplicand when the multiplier LSB is set, then shift {acc,low} right.
   // Div: shift the next dividend bit into the remainder, keep the trial difference
   //      if it did not borrow (top bit clear) and record the quotient bit.
   always_comb begin
      w_mulSum   = {1'b0, i_acc} + (i_low[0] ? {1'b0, i_operand} : '0);
      w_divShift = {i_acc, i_low[DATA_WIDTH-1]};
      w_divDiff  = w_divShift - {1'b0, i_operand};
      o_acc      = w_mulSum[DATA_WIDTH:1];
      o_low      = {w_mulSum[0], i_low[DATA_WIDTH-1:1]};
      if (i_isDiv) begin
         if (!w_divDiff[DATA_WIDTH]) begin
            o_acc = w_divDiff[DATA_WIDTH-1:0];
            o_low = {i_low[DATA_WIDTH-2:0], 1'b1};
         end else begin
            o_acc = w_divShift[DATA_WIDTH-1:0];
            o_low = {i_low[DATA_WIDTH-2:0], 1'b0};
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/hi_lo_muldiv_unit.sv
`default_nettype none
//==============================================================================
// Module      : hi_lo_muldiv_unit
// Description : Architectural HI/LO registers with iterative MULT/MULTU/DIV/
//               DIVU/MADD and single-cycle MTHI/MTLO. Busy stalls the pipe
//               for DATA_WIDTH+1 cycles per iterative op.
// Revision    : 1.0 - initial release
//==============================================================================
module hi_lo_muldiv_unit
   import hi_lo_muldiv_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input wire logic           Clk,
   input wire logic           Reset,
   hi_lo_muldiv_unit_if.slave bus
);
   localparam int                CNT_W       = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  c_lastCount = CNT_W'(DATA_WIDTH - 1);

   state_t                  r_state;
   logic                    r_busy;
   logic [CNT_W-1:0]        r_count;
   logic [DATA_WIDTH-1:0]   r_hi;
   logic [DATA_WIDTH-1:0]   r_lo;
   logic [DATA_WIDTH-1:0]   r_acc;       // partial product high half / remainder
   logic [DATA_WIDTH-1:0]   r_low;       // multiplier -> product low half / dividend -> quotient
   logic [DATA_WIDTH-1:0]   r_operand;   // multiplicand or divisor magnitude
   logic [DATA_WIDTH-1:0]   r_dividend;  // raw OperandA, returned in HI on divide-by-zero
   logic                    r_isDiv;
   logic                    r_isMadd;
   logic                    r_negLow;    // negate product (mul) or quotient (div)
   logic                    r_negRem;    // negate remainder
   logic                    r_divZero;

   logic                    w_signedOp;
   logic                    w_signA;
   logic                    w_signB;
   logic [DATA_WIDTH-1:0]   w_absA;
   logic [DATA_WIDTH-1:0]   w_absB;
   logic [DATA_WIDTH-1:0]   w_stepAcc;
   logic [DATA_WIDTH-1:0]   w_stepLow;
   logic [2*DATA_WIDTH-1:0] w_product;
   logic [2*DATA_WIDTH-1:0] w_signedProduct;
   logic [2*DATA_WIDTH-1:0] w_mulResult;
   logic [DATA_WIDTH-1:0]   w_fixHi;
   logic [DATA_WIDTH-1:0]   w_fixLo;

   // Operand pre-processing: magnitudes for signed ops, raw values otherwise.
   always_comb begin
      w_signedOp = isSignedOp(bus.Op);
      w_signA    = w_signedOp & bus.OperandA[DATA_WIDTH-1];
      w_signB    = w_signedOp & bus.OperandB[DATA_WIDTH-1];
      w_absA     = w_signA ? -bus.OperandA : bus.OperandA;
      w_absB     = w_signB ? -bus.OperandB : bus.OperandB;
   end

   iter_muldiv_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .i_isDiv   (r_isDiv),
      .i_acc     (r_acc),
      .i_low     (r_low),
      .i_operand (r_operand),
      .o_acc     (w_stepAcc),
      .o_low     (w_stepLow)
   );

   // Sign correction and MADD accumulation applied in the FIX cycle.
   always_comb begin
      w_product       = {r_acc, r_low};
      w_signedProduct = r_negLow ? -w_product : w_product;
      w_mulResult     = r_isMadd ? ({r_hi, r_lo} + w_signedProduct) : w_signedProduct;
      w_fixHi         = w_mulResult[2*DATA_WIDTH-1:DATA_WIDTH];
      w_fixLo         = w_mulResult[DATA_WIDTH-1:0];
      if (r_isDiv) begin
         if (r_divZero) begin
            w_fixHi = r_dividend;
            w_fixLo = '1;
         end else begin
            w_fixHi = r_negRem ? -r_acc : r_acc;
            w_fixLo = r_negLow ? -r_low : r_low;
         end
      end
   end

   // Control FSM with the HI/LO registers and iteration datapath state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_count    <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_acc      <= '0;
         r_low      <= '0;
         r_operand  <= '0;
         r_dividend <= '0;
         r_isDiv    <= 1'b0;
         r_isMadd   <= 1'b0;
         r_negLow   <= 1'b0;
         r_negRem   <= 1'b0;
         r_divZero  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.Start) begin
                  case (bus.Op)
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD: begin
                        r_acc      <= '0;
                        r_low      <= isDivOp(bus.Op) ? w_absA : w_absB;
                        r_operand  <= isDivOp(bus.Op) ? w_absB : w_absA;
                        r_dividend <= bus.OperandA;
                        r_isDiv    <= isDivOp(bus.Op);
                        r_isMadd   <= (bus.Op == OP_MADD);
                        r_negLow   <= w_signA ^ w_signB;
                        r_negRem   <= w_signA;
                        r_divZero  <= isDivOp(bus.Op) && (bus.OperandB == '0);
                        r_count    <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                     end
                     OP_MTHI: r_hi <= bus.OperandA;
                     OP_MTLO: r_lo <= bus.OperandA;
                     default: ;  // OP_NOP
                  endcase
               end
            end
            ST_RUN: begin
               r_acc <= w_stepAcc;
               r_low <= w_stepLow;
               if (r_count == c_lastCount) begin
                  r_state <= ST_FIX;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            ST_FIX: begin
               r_hi    <= w_fixHi;
               r_lo    <= w_fixLo;
               r_count <= '0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ReadDataHi = r_hi;
   assign bus.ReadDataLo = r_lo;
   assign bus.Busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_muldiv_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_hi_lo_muldiv_unit
// Description : Directed, table-driven bench for hi_lo_muldiv_unit.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_hi_lo_muldiv_unit;
   import hi_lo_muldiv_unit_pkg::*;

   localparam int DW        = 32;
   localparam int ITER_LAT  = DW + 1;
   localparam int BUSY_MAX  = 100;
   localparam int NUM_VECS  = 18;

   typedef struct {
      logic [2:0]    op;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] preHi;
      logic [DW-1:0] preLo;
      logic [DW-1:0] expHi;
      logic [DW-1:0] expLo;
   } vec_t;

   logic Clk = 1'b0;
   logic Reset;
   int   nApplied = 0;
   int   nMiscompares = 0;
   vec_t vecs [NUM_VECS];

   hi_lo_muldiv_unit_if #(.DATA_WIDTH(DW)) bus ();

   hi_lo_muldiv_unit #(
      .DATA_WIDTH (DW)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nApplied++;
      if (act !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one request for a single edge, then count sampled Busy-high cycles.
   task automatic runOp(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int busyCycles);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Op = op;
      bus.OperandA = a;
      bus.OperandB = b;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      bus.Op = OP_NOP;
      busyCycles = 0;
      while (bus.Busy && busyCycles < BUSY_MAX) begin
         busyCycles++;
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      int  cyc;
      int  expCyc;
      int  extra;
      bit  iter;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0,        32'h00000002, 32'hFFFFFFFA};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'h0, 32'h0,        32'h00000007, 32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1,        32'h00000000, 32'h80000000};
      vecs[5]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,        32'hFFFFFFFE, 32'h00000001};
      vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'h0, 32'h0,        32'h00000002, 32'h0000000E};
      vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,        32'h00000001, 32'hFFFFFFFD};
      vecs[8]  = '{OP_MADD,  32'd3,        32'd4,        32'h0, 32'h5,        32'h00000000, 32'h00000011};
      vecs[9]  = '{OP_MADD,  32'hFFFFFFFF, 32'd1,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[10] = '{OP_MADD,  32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
      vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'h0, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[12] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,        32'h40000000, 32'h00000000};
      vecs[13] = '{OP_MULT,  32'd7,        32'hFFFFFFFD, 32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[14] = '{OP_MTHI,  32'h12345678, 32'h0,        32'h0, 32'hAB,       32'h12345678, 32'h000000AB};
      vecs[15] = '{OP_MTLO,  32'h9,        32'h0,        32'h1, 32'h2,        32'h00000001, 32'h00000009};
      vecs[16] = '{OP_NOP,   32'hFF,       32'hFF,       32'h3, 32'h4,        32'h00000003, 32'h00000004};
      vecs[17] = '{OP_MADD,  32'hFFFFFFFE, 32'd3,        32'h0, 32'd10,       32'h00000000, 32'h00000004};

      bus.Start = 1'b0;
      bus.Op = OP_NOP;
      bus.OperandA = '0;
      bus.OperandB = '0;

      // Reset state
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      check("reset_hilo", {bus.ReadDataHi, bus.ReadDataLo}, 64'h0);
      check("reset_busy", 64'(bus.Busy), 64'h0);
      Reset = 1'b0;

      // Table-driven vectors: preload HI/LO, run the op, check result and latency
      for (int i = 0; i < NUM_VECS; i++) begin
         runOp(OP_MTHI, vecs[i].preHi, '0, cyc);
         runOp(OP_MTLO, vecs[i].preLo, '0, cyc);
         iter = (vecs[i].op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD});
         expCyc = iter ? ITER_LAT : 0;
         runOp(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
         check($sformatf("vec%0d_busy_cycles", i), 64'(cyc), 64'(expCyc));
         check($sformatf("vec%0d_hilo", i), {bus.ReadDataHi, bus.ReadDataLo},
               {vecs[i].expHi, vecs[i].expLo});
      end

      // Start while Busy is ignored; Busy falls exactly once
      runOp(OP_MTHI, 32'h77, '0, cyc);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Op = OP_MULT;
      bus.OperandA = 32'd5;
      bus.OperandB = 32'd6;
      @(posedge Clk);
      #1;
      bus.Op = OP_DIV;
      bus.OperandA = 32'd100;
      bus.OperandB = 32'd3;
      cyc = 0;
      while (bus.Busy && cyc < BUSY_MAX) begin
         cyc++;
         if (cyc == 2) begin
            bus.Start = 1'b0;
            bus.Op = OP_NOP;
         end
         @(posedge Clk);
         #1;
      end
      bus.Start = 1'b0;
      bus.Op = OP_NOP;
      check("busy_ignore_cycles", 64'(cyc), 64'(ITER_LAT));
      check("busy_ignore_hilo", {bus.ReadDataHi, bus.ReadDataLo}, {32'h0, 32'd30});
      extra = 0;
      repeat (5) begin
         @(posedge Clk);
         #1;
         if (bus.Busy) extra++;
      end
      check("busy_ignore_no_rerun", 64'(extra), 64'h0);

      // Reset in the middle of RUN discards the in-flight result
      runOp(OP_MTHI, 32'hAAAA, '0, cyc);
      runOp(OP_MTLO, 32'h5555, '0, cyc);
      @(negedge Clk);
      bus.Start = 1'b1;
      bus.Op = OP_MULT;
      bus.OperandA = 32'd5;
      bus.OperandB = 32'd6;
      @(posedge Clk);
      #1;
      bus.Start = 1'b0;
      bus.Op = OP_NOP;
      repeat (10) begin
         @(posedge Clk);
         #1;
      end
      check("midrun_busy", 64'(bus.Busy), 64'h1);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      check("midrun_reset_hilo", {bus.ReadDataHi, bus.ReadDataLo}, 64'h0);
      check("midrun_reset_busy", 64'(bus.Busy), 64'h0);
      extra = 0;
      repeat (40) begin
         @(posedge Clk);
         #1;
         if (bus.Busy) extra++;
      end
      check("midrun_no_late_write", {bus.ReadDataHi, bus.ReadDataLo}, 64'h0);
      check("midrun_no_late_busy", 64'(extra), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
      $finish;
   end

endmodule
`default_nettype wire
